// File: rtl/ranc_sched_pkg.sv
// Shared definitions for the axon spike scheduler: packet field layout and
// the slot-addressing / delay-legality helpers used by the write decoder.
package ranc_sched_pkg;

  // A packet is {delay, axon}. The axon field sits at the bottom, so the
  // delay field starts right above it.
  localparam int AXON_LSB = 0;

  function automatic int delay_lsb(input int axon_w);
    return AXON_LSB + axon_w;
  endfunction

  // Slot that a packet lands in: one past the current read slot, plus the
  // delay, modulo the (power-of-two) number of slots.
  function automatic logic [31:0] target_slot(input logic [31:0] rd_ptr,
                                              input logic [31:0] delay,
                                              input int unsigned num_slots);
    return (rd_ptr + 32'd1 + delay) & (num_slots - 32'd1);
  endfunction

  // The largest delay would wrap onto the slot being read right now.
  function automatic logic delay_legal(input logic [31:0] delay,
                                       input int unsigned num_slots);
    return (delay != (num_slots - 32'd1));
  endfunction

endpackage

// File: rtl/sched_collision_counter.sv
// Saturating counter of write collisions: sums up to NUM_IN hit strobes per
// cycle and adds them to a CNT_W-bit count that sticks at all-ones.
// A clear in the same cycle wins over any increments.
module sched_collision_counter #(
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic [NUM_IN-1:0] hit,
  output logic [CNT_W-1:0]  count
);

  localparam int INC_W = $clog2(NUM_IN + 1);

  logic [INC_W-1:0] inc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] count_next;

  // Popcount of this cycle's hits and the saturated running total.
  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      inc = inc + INC_W'(hit[i]);
    end
    sum        = {1'b0, count} + (CNT_W + 1)'(inc);
    count_next = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // Count register with synchronous reset and clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/axon_spike_scheduler.sv
// Axon spike scheduler: a circular bank of per-tick delay slots. Packets
// from NUM_CH channels set bits in future slots; each tick retires the
// current slot (clearing it) and advances the read pointer. The current
// slot is presented to the neuron grid as axon_spikes.
module axon_spike_scheduler
  import ranc_sched_pkg::*;
#(
  parameter int NUM_AXONS = 256,
  parameter int NUM_SLOTS = 16,
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 16,
  parameter int AXON_W    = $clog2(NUM_AXONS),
  parameter int DELAY_W   = $clog2(NUM_SLOTS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           tick,
  input  logic [NUM_CH-1:0]              wen,
  input  logic [NUM_CH*(DELAY_W+AXON_W)-1:0] packet,
  input  logic                           err_clr,
  output logic [NUM_AXONS-1:0]           axon_spikes,
  output logic                           error,
  output logic [CNT_W-1:0]               collision_count
);

  localparam int PW        = DELAY_W + AXON_W;
  localparam int DELAY_LSB = delay_lsb(AXON_W);

  logic [NUM_AXONS-1:0] slot_bank [NUM_SLOTS];
  logic [DELAY_W-1:0]   rd_ptr;

  logic [DELAY_W-1:0] ch_delay [NUM_CH];
  logic [AXON_W-1:0]  ch_axon  [NUM_CH];
  logic [DELAY_W-1:0] ch_slot  [NUM_CH];
  logic [NUM_CH-1:0]  ch_valid;
  logic [NUM_CH-1:0]  ch_illegal;
  logic [NUM_CH-1:0]  ch_hit;

  assign axon_spikes = slot_bank[rd_ptr];

  // Decode each channel: target slot, legality, and whether the write
  // lands on a bit that is already set (earlier write, or a lower channel
  // writing the same slot/axon this cycle).
  always_comb begin
    ch_valid   = '0;
    ch_illegal = '0;
    ch_hit     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_delay[c] = packet[c*PW + DELAY_LSB +: DELAY_W];
      ch_axon[c]  = packet[c*PW + AXON_LSB +: AXON_W];
      ch_slot[c]  = DELAY_W'(target_slot(32'(rd_ptr), 32'(ch_delay[c]),
                                         NUM_SLOTS));
      if (wen[c]) begin
        if (delay_legal(32'(ch_delay[c]), NUM_SLOTS) &&
            (32'(ch_axon[c]) < 32'(NUM_AXONS))) begin
          ch_valid[c] = 1'b1;
        end else begin
          ch_illegal[c] = 1'b1;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_valid[c]) begin
        if (slot_bank[ch_slot[c]][ch_axon[c]]) begin
          ch_hit[c] = 1'b1;
        end
        for (int j = 0; j < c; j++) begin
          if (ch_valid[j] && (ch_slot[j] == ch_slot[c]) &&
              (ch_axon[j] == ch_axon[c])) begin
            ch_hit[c] = 1'b1;
          end
        end
      end
    end
  end

  // Slot bank and read pointer. A legal write never targets the slot being
  // retired by a tick, so the clear and the bit sets cannot overlap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_bank[s] <= '0;
      end
      rd_ptr <= '0;
    end else begin
      if (tick) begin
        slot_bank[rd_ptr] <= '0;
        rd_ptr            <= rd_ptr + DELAY_W'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_valid[c]) begin
          slot_bank[ch_slot[c]][ch_axon[c]] <= 1'b1;
        end
      end
    end
  end

  // Sticky illegal-write flag; a new illegal write beats a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if (|ch_illegal) begin
      error <= 1'b1;
    end else if (err_clr) begin
      error <= 1'b0;
    end
  end

  sched_collision_counter #(
    .NUM_IN (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_collision_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (err_clr),
    .hit     (ch_hit),
    .count   (collision_count)
  );

endmodule

// File: doc/axon_spike_scheduler.md
Name: axon_spike_scheduler

Overview:
- Parametrised, multi-channel successor to the fixed 256-axon / 16-slot / single-input core scheduler.
- Buffers incoming axon spike packets in a circular bank of per-tick delay slots.
- Presents the current tick's axon spike vector to the neuron grid.
- Adds: N write channels per cycle (router + local loopback), illegal-delay detection, and a saturating collision counter.

Parameters:
- NUM_AXONS, 256: axons per core; width of the spike vector.
- NUM_SLOTS, 16: delay slots; must be a power of two, ≥2.
- NUM_CH, 2: independent packet write channels.
- CNT_W, 16: width of the collision counter.
- AXON_W, $clog2(NUM_AXONS): derived; do not override.
- DELAY_W, $clog2(NUM_SLOTS): derived; do not override.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- tick  in  1  one-cycle pulse; advances the slot window
- wen  in  NUM_CH  per-channel packet write strobe
- packet  in  NUM_CH*(DELAY_W+AXON_W)  channel c at bits [c*PW +: PW]; each packet is {delay, axon}
- err_clr  in  1  clears error and collision_count
- axon_spikes  out  NUM_AXONS  spike vector of the current slot
- error  out  1  sticky illegal-delay flag
- collision_count  out  CNT_W  saturating count of writes that hit an already-set bit

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are clk and reset_n.
- State:
  - slot bank: NUM_SLOTS x NUM_AXONS flops.
  - rd_ptr: DELAY_W bits.
  - error flop; collision_count register.
- Reset (reset_n=0 at a clk edge): all slots 0, rd_ptr=0, error=0, collision_count=0, so axon_spikes=0 from the next cycle. Reset mid-operation discards all pending spikes; tick/wen in that cycle are ignored.
- Output: axon_spikes = slot[rd_ptr], read combinationally from registers. It changes only on the cycle after a tick or a reset.
- Write, per channel c with wen[c]=1:
  - d = packet delay field, a = axon field.
  - Target slot t = (rd_ptr + 1 + d) mod NUM_SLOTS, using the pre-tick rd_ptr.
  - Legal d is 0..NUM_SLOTS-2; bit slot[t][a] is set at the clock edge.
  - d = NUM_SLOTS-1 is illegal: the write is dropped and error is set the next cycle.
  - a ≥ NUM_AXONS (only possible when NUM_AXONS is not a power of two) is dropped the same way and sets error.
- Tick (tick=1): rd_ptr ← rd_ptr+1 (wraps NUM_SLOTS-1→0), and slot[old rd_ptr] is cleared to 0 in the same edge.
  - A write in the tick cycle never targets old rd_ptr, so the clear and writes never conflict.
  - A delay-0 write in the tick cycle lands in the new current slot and is visible on axon_spikes the cycle after the tick.
- Multiple channels, same cycle: all legal writes are ORed into the bank.
- Collisions: each write whose target bit is already 1 (pre-edge), or which duplicates a lower-numbered channel's (t,a) in the same cycle, adds 1 to collision_count. Multiple increments per cycle are summed; the counter saturates at 2^CNT_W-1.
- err_clr:
  - error ← 0 and collision_count ← 0.
  - If an illegal write occurs in the same cycle, error ends at 1 (set wins).
  - Collisions in the same cycle are dropped (clear wins).
- tick held high for k cycles advances the window k slots. No other handshake exists; writes are always accepted (no backpressure).
- Latency: write → visible 1 + d ticks later (one cycle after the (d+1)-th tick).

Decomposition:
- Package ranc_sched_pkg:
  - packet field offsets (DELAY_LSB, AXON_LSB);
  - function target_slot(rd_ptr, delay);
  - function delay_legal(delay).
- Sub-module sched_collision_counter: NUM_CH-input popcount plus saturating add, with clear. The bank and pointer stay in the top module.

Test Plan (NUM_AXONS=256, NUM_SLOTS=16, NUM_CH=2, CNT_W=16):
1. Hold reset_n=0 for 2 cycles then release → axon_spikes=0, error=0, collision_count=0.
2. ch0 packet {d=0,a=5}, then tick → cycle after tick axon_spikes[5]=1, others 0; second tick → axon_spikes=0.
3. ch1 {d=3,a=200} → axon_spikes[200]=0 after ticks 1–3; =1 after tick 4; cleared after tick 5. Repeat across the rd_ptr 15→0 wrap with identical result.
4. ch0 and ch1 both {d=2,a=7} same cycle, then ch0 {d=2,a=7} again → bit 7 set once after tick 3; collision_count=2.
5. ch0 {d=15,a=9} → error=1 next cycle; bit 9 never set over 16 ticks. err_clr → error=0, collision_count=0. err_clr coincident with another d=15 write → error stays 1.
6. ch0 {d=0,a=42} in the same cycle as tick → axon_spikes[42]=1 the cycle after that tick. Assert reset_n=0 mid-run with pending slots → all slots cleared; no spike appears on later ticks.
